// File: rtl/bottle_detector.sv
// bottle_detector: conditions the beam-break sensor of the reverse vending
// machine and classifies each beam-break event. The result is one of three:
// accepted (bc_pulse), too short (reject_pulse), or too long (jam).
module bottle_detector #(
    parameter int DEB_CYCLES = 16,
    parameter int MIN_DWELL  = 1000,
    parameter int MAX_DWELL  = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_raw,
    input  logic enable,
    input  logic jam_clr,
    output logic bc_pulse,
    output logic reject_pulse,
    output logic jam,
    output logic busy
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int DW_W  = $clog2(MAX_DWELL + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    // dwell_q excludes the rise cycle, which is spent in IDLE. For that reason
    // both thresholds are shifted down by one. The jam threshold is shifted down
    // by two because the cycle being evaluated is itself a high cycle.
    localparam logic [DW_W-1:0]  ACC_TH   = DW_W'(MIN_DWELL - 1);
    localparam logic [DW_W-1:0]  JAM_TH   = DW_W'(MAX_DWELL - 2);
    localparam logic [DW_W-1:0]  DW_ONE   = DW_W'(1);
    localparam logic [DW_W-1:0]  DW_MAX   = DW_W'(MAX_DWELL);

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_JAM} state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               sensor_f_q, sensor_f_d;
    logic               sensor_f_dly_q, sensor_f_dly_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic               bc_pulse_q, bc_pulse_d;
    logic               reject_pulse_q, reject_pulse_d;
    logic               sensor_s;
    logic               rise_f;
    logic               fall_f;

    assign sensor_s = sync2_q;
    assign rise_f   = sensor_f_q & ~sensor_f_dly_q;
    assign fall_f   = ~sensor_f_q & sensor_f_dly_q;

    // Two-flop synchroniser, then a level filter. A level filter only follows
    // sensor_s after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        sync1_d        = sensor_raw;
        sync2_d        = sync1_q;
        sensor_f_d     = sensor_f_q;
        deb_cnt_d      = deb_cnt_q;
        sensor_f_dly_d = sensor_f_q;
        if (sensor_s == sensor_f_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            sensor_f_d = sensor_s;
            deb_cnt_d  = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
    end

    // Presence FSM: dwell measurement, classification and jam handling.
    always_comb begin
        state_d        = state_q;
        dwell_d        = dwell_q;
        bc_pulse_d     = 1'b0;
        reject_pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise_f && enable) begin
                    state_d = S_PRESENT;
                    dwell_d = '0;
                end
            end
            S_PRESENT: begin
                if (fall_f) begin
                    if (dwell_q >= ACC_TH) bc_pulse_d     = 1'b1;
                    else                   reject_pulse_d = 1'b1;
                    state_d = S_IDLE;
                end else if (sensor_f_q) begin
                    if (dwell_q != DW_MAX) dwell_d = dwell_q + DW_ONE;
                    if (dwell_q == JAM_TH) state_d = S_JAM;
                end
            end
            S_JAM: begin
                if (jam_clr && !sensor_f_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sensor_f_q     <= 1'b0;
            sensor_f_dly_q <= 1'b0;
            deb_cnt_q      <= '0;
            dwell_q        <= '0;
            bc_pulse_q     <= 1'b0;
            reject_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sensor_f_q     <= sensor_f_d;
            sensor_f_dly_q <= sensor_f_dly_d;
            deb_cnt_q      <= deb_cnt_d;
            dwell_q        <= dwell_d;
            bc_pulse_q     <= bc_pulse_d;
            reject_pulse_q <= reject_pulse_d;
        end
    end

    assign bc_pulse     = bc_pulse_q;
    assign reject_pulse = reject_pulse_q;
    assign jam          = (state_q == S_JAM);
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_bottle_detector.sv
// Bench for bottle_detector. Directed scenarios are followed by random
// bottles. Every cycle is checked against a bottle-level reference model.
module tb_bottle_detector;
    localparam int DEB = 4;
    localparam int MIN = 10;
    localparam int MAX = 40;

    logic clk = 1'b0;
    logic reset, sensor_raw, enable, jam_clr;
    logic bc_pulse, reject_pulse, jam, busy;

    bottle_detector #(.DEB_CYCLES(DEB), .MIN_DWELL(MIN), .MAX_DWELL(MAX)) dut (
        .clk(clk), .reset(reset), .sensor_raw(sensor_raw), .enable(enable),
        .jam_clr(jam_clr), .bc_pulse(bc_pulse), .reject_pulse(reject_pulse),
        .jam(jam), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model. raw_hist[0] holds the newest raw sample. The filtered
    // level flips once DEB synchronised samples (2-cycle delay) all disagree.
    typedef enum {M_IDLE, M_BOTTLE, M_JAMMED} mmode_t;
    logic   raw_hist [DEB+2];
    logic   mf, mf_prev;
    mmode_t mode;
    int     highs;
    logic   e_bc, e_rej;
    int     bc_seen = 0, rej_seen = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic en, input logic clr, input logic rs);
        logic nf;
        logic all_diff;
        e_bc  = 1'b0;
        e_rej = 1'b0;
        if (rs) begin
            for (int i = 0; i < DEB + 2; i++) raw_hist[i] = 1'b0;
            mf = 1'b0; mf_prev = 1'b0; mode = M_IDLE; highs = 0;
        end else begin
            for (int i = DEB + 1; i > 0; i--) raw_hist[i] = raw_hist[i-1];
            raw_hist[0] = r;
            all_diff = 1'b1;
            for (int i = 2; i < DEB + 2; i++) if (raw_hist[i] == mf) all_diff = 1'b0;
            nf = all_diff ? ~mf : mf;
            // mf is the filtered level during the cycle that just ended.
            case (mode)
                M_IDLE:   if (mf && !mf_prev && en) begin mode = M_BOTTLE; highs = 1; end
                M_BOTTLE: if (!mf) begin
                              if (highs >= MIN) e_bc = 1'b1; else e_rej = 1'b1;
                              mode = M_IDLE;
                          end else begin
                              highs++;
                              if (highs >= MAX) mode = M_JAMMED;
                          end
                M_JAMMED: if (clr && !mf) mode = M_IDLE;
                default:  mode = M_IDLE;
            endcase
            mf_prev = mf;
            mf = nf;
        end
    endtask

    // One clock: drive inputs, step the model at the edge, check 1 time unit later.
    task automatic cyc(input logic r, input logic en, input logic clr, input logic rs);
        sensor_raw = r; enable = en; jam_clr = clr; reset = rs;
        @(posedge clk);
        model_edge(r, en, clr, rs);
        #1;
        chk("bc_pulse", bc_pulse, e_bc);
        chk("reject_pulse", reject_pulse, e_rej);
        chk("jam", jam, mode == M_JAMMED);
        chk("busy", busy, mode != M_IDLE);
        if (bc_pulse) bc_seen++;
        if (reject_pulse) rej_seen++;
    endtask

    task automatic hold(input int n, input logic r, input logic en);
        for (int i = 0; i < n; i++) cyc(r, en, 1'b0, 1'b0);
    endtask

    initial begin
        int bc0, rej0, first_busy, len, gap;
        logic en_r;
        for (int i = 0; i < DEB + 2; i++) raw_hist[i] = 1'b0;
        mf = 1'b0; mf_prev = 1'b0; mode = M_IDLE; highs = 0; e_bc = 1'b0; e_rej = 1'b0;
        sensor_raw = 1'b0; enable = 1'b0; jam_clr = 1'b0; reset = 1'b1;

        // Reset with the sensor low: all outputs 0, busy stays 0 afterwards.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_bc", bc_pulse, 1'b0);
        chk("rst_rej", reject_pulse, 1'b0);
        chk("rst_jam", jam, 1'b0);
        chk("rst_busy", busy, 1'b0);
        hold(20, 1'b0, 1'b1);

        // Glitch of 3 cycles is filtered out.
        bc0 = bc_seen; rej0 = rej_seen;
        hold(3, 1'b1, 1'b1);
        hold(15, 1'b0, 1'b1);
        chk_int("glitch_pulses", (bc_seen - bc0) + (rej_seen - rej0), 0);

        // 10-cycle bottle: accepted, busy follows raw rise by 2+DEB+1 edges.
        bc0 = bc_seen; rej0 = rej_seen; first_busy = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (busy && first_busy == 0) first_busy = i;
        end
        hold(12, 1'b0, 1'b1);
        chk_int("rise_to_busy", first_busy, 7);
        chk_int("accept_bc", bc_seen - bc0, 1);
        chk_int("accept_rej", rej_seen - rej0, 0);

        // 9-cycle bottle: rejected.
        bc0 = bc_seen; rej0 = rej_seen;
        hold(9, 1'b1, 1'b1);
        hold(12, 1'b0, 1'b1);
        chk_int("short_bc", bc_seen - bc0, 0);
        chk_int("short_rej", rej_seen - rej0, 1);

        // Jam: 6 debounce edges + 40 high cycles; clear is ignored while blocked.
        bc0 = bc_seen; rej0 = rej_seen;
        hold(46, 1'b1, 1'b1);
        chk("jam_set", jam, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("jam_clr_blocked", jam, 1'b1);
        hold(8, 1'b0, 1'b1);
        chk("jam_still", jam, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("jam_cleared", jam, 1'b0);
        chk("jam_busy", busy, 1'b0);
        hold(4, 1'b0, 1'b1);
        chk_int("jam_pulses", (bc_seen - bc0) + (rej_seen - rej0), 0);

        // Enable gating: disabled bottle, then sensor already high at enable.
        bc0 = bc_seen; rej0 = rej_seen;
        hold(15, 1'b1, 1'b0);
        hold(12, 1'b0, 1'b0);
        hold(10, 1'b1, 1'b0);
        hold(15, 1'b1, 1'b1);
        hold(12, 1'b0, 1'b1);
        chk_int("gated_pulses", (bc_seen - bc0) + (rej_seen - rej0), 0);

        // Enable dropped mid-bottle: bottle still completes.
        bc0 = bc_seen;
        hold(9, 1'b1, 1'b1);
        hold(6, 1'b1, 1'b0);
        hold(12, 1'b0, 1'b0);
        chk_int("en_drop_bc", bc_seen - bc0, 1);

        // Reset 5 cycles into PRESENT with the sensor still high at release.
        bc0 = bc_seen; rej0 = rej_seen;
        hold(12, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk_int("midrst_pulses", (bc_seen - bc0) + (rej_seen - rej0), 0);
        first_busy = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (busy && first_busy == 0) first_busy = i;
        end
        chk_int("midrst_rebusy", first_busy, 7);
        hold(12, 1'b0, 1'b1);

        // Random bottles, glitches, gaps, enable changes and jam clears.
        for (int n = 0; n < 40; n++) begin
            len  = $urandom_range(55, 1);
            gap  = $urandom_range(20, 1);
            en_r = ($urandom_range(4, 0) != 0);
            for (int i = 0; i < len; i++)
                cyc(1'b1, ($urandom_range(9, 0) == 0) ? ~en_r : en_r,
                    ($urandom_range(7, 0) == 0), ($urandom_range(199, 0) == 0));
            for (int i = 0; i < gap; i++)
                cyc(1'b0, en_r, ($urandom_range(3, 0) == 0), 1'b0);
        end
        hold(10, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        hold(3, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
